// File: rtl/backprop_sequencer_pkg.sv
// Shared types and constants for the backprop sequencer slice.
package backprop_pkg;

   // Width of every index field carried in the control bundle.
   localparam int IDX_W    = 32;
   localparam int PULSE_W  = 4;
   localparam int BUNDLE_W = 3 * IDX_W + PULSE_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_CAL,
      ST_STORE,
      ST_DYDY,
      ST_DONE
   } state_e;

   // Low nibble of the bundle, MSB first.
   typedef struct packed {
      logic update_storage;
      logic update_dy_dy_old;
      logic cal_dc_dw;
      logic reset_bit;
   } pulse_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/backprop_sequencer_if.sv
// Handshake/control bundle between the sequencer and its environment.
interface backprop_sequencer_if
   import backprop_pkg::*;
#(
   parameter int backprop_controll_size = BUNDLE_W
) ();

   logic                              start;
   logic                              stall;
   logic [backprop_controll_size-1:0] backprop_controll_bundle;
   logic                              busy;
   logic                              done;

   // Environment side: issues requests and stalls, observes control.
   modport master (
      output start,
      output stall,
      input  backprop_controll_bundle,
      input  busy,
      input  done
   );

   // Sequencer side.
   modport slave (
      input  start,
      input  stall,
      output backprop_controll_bundle,
      output busy,
      output done
   );

endinterface

// File: rtl/backprop_sequencer_index_counter.sv
// Loadable up/down index counter. wrap_o flags the terminal value for the
// current direction (MAX when counting up, 0 when counting down); an enabled
// step from that value wraps around.
module backprop_index_counter #(
   parameter int W   = 2,
   parameter int MAX = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   input  logic         up_i,
   output logic [W-1:0] count_o,
   output logic         wrap_o
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: load has priority over a step.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i) begin
         if (up_i) begin
            count_d = wrap_o ? '0 : count_q + 1'b1;
         end else begin
            count_d = wrap_o ? MAX_V : count_q - 1'b1;
         end
      end
   end

   // Counter register with synchronous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign wrap_o  = up_i ? (count_q == MAX_V) : (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/backprop_sequencer.sv
// Backprop pass sequencer: walks layers top-down, emitting one clear, a run
// of dc/dw row steps, a storage update and a dy/dy update per layer.
module backprop_sequencer
   import backprop_pkg::*;
#(
   parameter int size                   = 3,
   parameter int data_size              = 16,
   parameter int layer_count            = 2,
   parameter int backprop_controll_size = 32 * 3 + 4
) (
   input  logic                 clk,
   input  logic                 reset,
   backprop_sequencer_if.slave  bus
);

   localparam int ROW_W   = idx_width(size);
   localparam int LAYER_W = idx_width(layer_count);

   state_e             state_q;
   pulse_t             pulse_q;
   logic               done_q;

   logic [ROW_W-1:0]   row_cnt;
   logic               row_last;
   logic [LAYER_W-1:0] layer_cnt;
   logic               layer_zero;

   logic               start_pass;
   logic               advance;
   logic               row_en;
   logic               layer_en;

   logic [IDX_W-1:0]   layer_field;
   logic [IDX_W-1:0]   row_field;

   // data_size only rides along in the parameter list.
   logic unused_data_size;
   assign unused_data_size = ^data_size;

   // Counter control: load on pass start, step only on unstalled cycles.
   always_comb begin
      start_pass = (state_q == ST_IDLE) && bus.start;
      advance    = (state_q != ST_IDLE) && !bus.stall;
      row_en     = advance && (state_q == ST_CAL);
      layer_en   = advance && (state_q == ST_DYDY) && !layer_zero;
   end

   backprop_index_counter #(
      .W   (ROW_W),
      .MAX (size - 1)
   ) u_row_cnt (
      .clk        (clk),
      .reset      (reset),
      .load_i     (start_pass),
      .load_val_i ('0),
      .en_i       (row_en),
      .up_i       (1'b1),
      .count_o    (row_cnt),
      .wrap_o     (row_last)
   );

   backprop_index_counter #(
      .W   (LAYER_W),
      .MAX (layer_count - 1)
   ) u_layer_cnt (
      .clk        (clk),
      .reset      (reset),
      .load_i     (start_pass),
      .load_val_i (LAYER_W'(layer_count - 1)),
      .en_i       (layer_en),
      .up_i       (1'b0),
      .count_o    (layer_cnt),
      .wrap_o     (layer_zero)
   );

   // Sequencing FSM; the pulse registers describe the state being entered,
   // and a stalled cycle holds the state with every pulse dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pulse_q <= '0;
         done_q  <= 1'b0;
      end else begin
         pulse_q <= '0;
         done_q  <= 1'b0;
         if (state_q == ST_IDLE) begin
            if (bus.start) begin
               state_q           <= ST_CLEAR;
               pulse_q.reset_bit <= 1'b1;
            end
         end else if (!bus.stall) begin
            case (state_q)
               ST_CLEAR: begin
                  state_q           <= ST_CAL;
                  pulse_q.cal_dc_dw <= 1'b1;
               end
               ST_CAL: begin
                  if (row_last) begin
                     state_q                <= ST_STORE;
                     pulse_q.update_storage <= 1'b1;
                  end else begin
                     pulse_q.cal_dc_dw <= 1'b1;
                  end
               end
               ST_STORE: begin
                  state_q                  <= ST_DYDY;
                  pulse_q.update_dy_dy_old <= 1'b1;
               end
               ST_DYDY: begin
                  if (layer_zero) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q           <= ST_CAL;
                     pulse_q.cal_dc_dw <= 1'b1;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Index fields are pure decodes of registers, so they are glitch-free and
   // hold naturally while stalled.
   always_comb begin
      layer_field = (state_q == ST_IDLE) ? '0 : IDX_W'(layer_cnt);
      row_field   = (state_q == ST_CAL)  ? IDX_W'(row_cnt) : '0;
   end

   assign bus.backprop_controll_bundle =
      backprop_controll_size'({layer_field, layer_field, row_field, pulse_q});
   assign bus.busy = (state_q != ST_IDLE);
   assign bus.done = done_q;

endmodule

// File: tb/tb_backprop_sequencer.sv
// Self-checking bench: fixed-timeline table, directed corner sequences and
// randomized traffic against a step-list reference model.
module tb_backprop_sequencer;
   import backprop_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   backprop_sequencer_if bus0 ();
   backprop_sequencer_if bus1 ();

   backprop_sequencer #(
      .size(3), .data_size(16), .layer_count(2), .backprop_controll_size(BUNDLE_W)
   ) dut0 (
      .clk(clk), .reset(reset), .bus(bus0)
   );

   backprop_sequencer #(
      .size(1), .data_size(16), .layer_count(1), .backprop_controll_size(BUNDLE_W)
   ) dut1 (
      .clk(clk), .reset(reset), .bus(bus1)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // ---------------- reference model: a pass is a list of steps ----------
   typedef struct packed {
      logic [3:0]  pulses;   // {storage, dydy, cal, reset_bit}
      logic        done;
      logic [31:0] layer;
      logic [31:0] row;
   } step_t;

   step_t steps [2][64];
   int    n_steps [2];
   int    pos [2];
   logic  active [2];
   step_t cur [2];

   function automatic int cfg_size(input int id);
      return (id == 0) ? 3 : 1;
   endfunction

   function automatic int cfg_layers(input int id);
      return (id == 0) ? 2 : 1;
   endfunction

   function automatic step_t mk_step(input logic [3:0] p, input logic d, input int l, input int r);
      step_t s;
      s.pulses = p;
      s.done   = d;
      s.layer  = 32'(l);
      s.row    = 32'(r);
      return s;
   endfunction

   task automatic build_pass(input int id);
      int n;
      n = 0;
      steps[id][n] = mk_step(4'b0001, 1'b0, cfg_layers(id) - 1, 0); n++;
      for (int l = cfg_layers(id) - 1; l >= 0; l--) begin
         for (int r = 0; r < cfg_size(id); r++) begin
            steps[id][n] = mk_step(4'b0010, 1'b0, l, r); n++;
         end
         steps[id][n] = mk_step(4'b1000, 1'b0, l, 0); n++;
         steps[id][n] = mk_step(4'b0100, 1'b0, l, 0); n++;
      end
      steps[id][n] = mk_step(4'b0000, 1'b1, 0, 0); n++;
      n_steps[id] = n;
   endtask

   task automatic model_edge(input int id, input logic st, input logic sl, input logic rs);
      if (rs) begin
         active[id] = 1'b0;
         cur[id]    = '0;
      end else if (!active[id]) begin
         if (st) begin
            build_pass(id);
            pos[id]    = 0;
            cur[id]    = steps[id][0];
            active[id] = 1'b1;
         end
      end else if (sl) begin
         cur[id].pulses = 4'b0000;
         cur[id].done   = 1'b0;
      end else if (pos[id] == n_steps[id] - 1) begin
         active[id] = 1'b0;
         cur[id]    = '0;
      end else begin
         pos[id]++;
         cur[id] = steps[id][pos[id]];
      end
   endtask

   // ---------------- checking helpers ------------------------------------
   task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic check_dut(input int id, input logic [BUNDLE_W-1:0] b, input logic bz, input logic dn);
      logic [BUNDLE_W-1:0] exp;
      exp = {cur[id].layer, cur[id].layer, cur[id].row, cur[id].pulses};
      checks++;
      if (b !== exp || bz !== active[id] || dn !== cur[id].done) begin
         errors++;
         $display("FAIL dut%0d_outputs (cycle %0d): got bundle=%h busy=%b done=%b, expected bundle=%h busy=%b done=%b",
                  id, cyc, b, bz, dn, exp, active[id], cur[id].done);
      end
      checks++;
      if ($countones(b[3:0]) > 1 || (!bz && b[BUNDLE_W-1:4] != '0)) begin
         errors++;
         $display("FAIL dut%0d_exclusive_idle_zero (cycle %0d): got pulses=%b busy=%b idx=%h, expected at most one pulse and zero idx when idle",
                  id, cyc, b[3:0], bz, b[BUNDLE_W-1:4]);
      end
   endtask

   // One clock: inputs are stable across the edge, outputs checked at negedge.
   task automatic tick();
      @(posedge clk);
      model_edge(0, bus0.start, bus0.stall, reset);
      model_edge(1, bus1.start, bus1.stall, reset);
      @(negedge clk);
      cyc++;
      check_dut(0, bus0.backprop_controll_bundle, bus0.busy, bus0.done);
      check_dut(1, bus1.backprop_controll_bundle, bus1.busy, bus1.done);
   endtask

   // ---------------- fixed timeline table --------------------------------
   typedef struct {
      logic       start;
      logic       stall;
      logic [3:0] pulses;
      logic       done;
      logic       busy;
      int         row;
      int         layer;
   } vec_t;

   vec_t tbl [14];

   function automatic vec_t mkv(input logic st, input logic sl, input logic [3:0] p,
                                input logic d, input logic bz, input int r, input int l);
      vec_t v;
      v.start = st; v.stall = sl; v.pulses = p; v.done = d; v.busy = bz; v.row = r; v.layer = l;
      return v;
   endfunction

   // ---------------- directed sequence recorder --------------------------
   logic [BUNDLE_W-1:0] hist [32];
   logic                busy_hist [32];
   logic                done_hist [32];

   task automatic run_seq(input int id, input int ncyc, input int start2,
                          input int stall_lo, input int stall_hi, input int rst_at);
      logic st, sl;
      for (int c = 0; c < ncyc; c++) begin
         st    = (c == 0) || (c == start2);
         sl    = (c >= stall_lo) && (c <= stall_hi);
         reset = (c == rst_at);
         if (id == 0) begin
            bus0.start = st; bus0.stall = sl;
         end else begin
            bus1.start = st; bus1.stall = sl;
         end
         tick();
         hist[c+1]      = (id == 0) ? bus0.backprop_controll_bundle : bus1.backprop_controll_bundle;
         busy_hist[c+1] = (id == 0) ? bus0.busy : bus1.busy;
         done_hist[c+1] = (id == 0) ? bus0.done : bus1.done;
      end
      reset = 1'b0;
      bus0.start = 1'b0; bus0.stall = 1'b0;
      bus1.start = 1'b0; bus1.stall = 1'b0;
      tick();
      tick();
   endtask

   // ---------------- main ------------------------------------------------
   initial begin
      logic [BUNDLE_W-1:0] expb;
      int pulse_cnt;

      for (int i = 0; i < 2; i++) begin
         active[i] = 1'b0; cur[i] = '0; pos[i] = 0; n_steps[i] = 0;
      end

      // Reset overriding start and stall.
      reset = 1'b1;
      bus0.start = 1'b1; bus0.stall = 1'b1;
      bus1.start = 1'b1; bus1.stall = 1'b1;
      @(negedge clk);
      tick();
      tick();
      check_eq("reset_state_bundle", 128'(bus0.backprop_controll_bundle), 128'(0));
      check_eq("reset_state_busy_done", 128'({bus0.busy, bus0.done}), 128'(0));
      reset = 1'b0;
      bus0.start = 1'b0; bus0.stall = 1'b0;
      bus1.start = 1'b0; bus1.stall = 1'b0;
      tick();
      $display("phase reset: done at cycle %0d", cyc);

      // Nominal pass, size=3 / layer_count=2.
      tbl[0]  = mkv(1, 0, 4'b0000, 0, 0, 0, 0);
      tbl[1]  = mkv(0, 0, 4'b0001, 0, 1, 0, 1);
      tbl[2]  = mkv(0, 0, 4'b0010, 0, 1, 0, 1);
      tbl[3]  = mkv(0, 0, 4'b0010, 0, 1, 1, 1);
      tbl[4]  = mkv(0, 0, 4'b0010, 0, 1, 2, 1);
      tbl[5]  = mkv(0, 0, 4'b1000, 0, 1, 0, 1);
      tbl[6]  = mkv(0, 0, 4'b0100, 0, 1, 0, 1);
      tbl[7]  = mkv(0, 0, 4'b0010, 0, 1, 0, 0);
      tbl[8]  = mkv(0, 0, 4'b0010, 0, 1, 1, 0);
      tbl[9]  = mkv(0, 0, 4'b0010, 0, 1, 2, 0);
      tbl[10] = mkv(0, 0, 4'b1000, 0, 1, 0, 0);
      tbl[11] = mkv(0, 0, 4'b0100, 0, 1, 0, 0);
      tbl[12] = mkv(0, 0, 4'b0000, 1, 1, 0, 0);
      tbl[13] = mkv(0, 0, 4'b0000, 0, 0, 0, 0);
      for (int k = 0; k < 14; k++) begin
         expb = {32'(tbl[k].layer), 32'(tbl[k].layer), 32'(tbl[k].row), tbl[k].pulses};
         check_eq($sformatf("table_bundle_c%0d", k), 128'(bus0.backprop_controll_bundle), 128'(expb));
         check_eq($sformatf("table_busy_done_c%0d", k), 128'({bus0.busy, bus0.done}),
                  128'({tbl[k].busy, tbl[k].done}));
         bus0.start = tbl[k].start;
         bus0.stall = tbl[k].stall;
         tick();
      end
      $display("phase table: nominal pass of 14 cycles applied");

      // Stall at cycles 3-4: row 1 held silent, everything later +2.
      run_seq(0, 17, -1, 3, 4, -1);
      check_eq("stall_c4_row_cal", 128'({hist[4][35:4], hist[4][3:0]}), 128'({32'd1, 4'b0000}));
      check_eq("stall_c5_row_cal", 128'({hist[5][35:4], hist[5][3:0]}), 128'({32'd1, 4'b0000}));
      check_eq("stall_c6_row2_cal", 128'({hist[6][35:4], hist[6][3:0]}), 128'({32'd2, 4'b0010}));
      check_eq("stall_storage_c7", 128'(hist[7][3:0]), 128'(4'b1000));
      check_eq("stall_done_c12_c14", 128'({done_hist[12], done_hist[14]}), 128'(2'b01));
      $display("phase stall: stalled pass finished");

      // Restart while busy is ignored.
      run_seq(0, 15, 5, 99, 99, -1);
      check_eq("restart_done_c12", 128'(done_hist[12]), 128'(1));
      check_eq("restart_idle_c13_c14", 128'({busy_hist[13], busy_hist[14], hist[13], hist[14]}), 128'(0));
      $display("phase restart: re-pulsed start ignored");

      // Reset mid-pass at cycle 8.
      run_seq(0, 16, -1, 99, 99, 8);
      check_eq("abort_c9_bundle_busy", 128'({busy_hist[9], hist[9]}), 128'(0));
      pulse_cnt = 0;
      for (int c = 9; c <= 16; c++) begin
         pulse_cnt += $countones(hist[c][3:0]) + int'(done_hist[c]) + int'(busy_hist[c]);
      end
      check_eq("abort_silent_after_reset", 128'(pulse_cnt), 128'(0));
      $display("phase abort: reset mid-pass");

      // Minimal configuration: size=1, layer_count=1.
      run_seq(1, 8, -1, 99, 99, -1);
      check_eq("tiny_c1_reset_bit", 128'(hist[1][3:0]), 128'(4'b0001));
      check_eq("tiny_c2_cal_row0", 128'({hist[2][35:4], hist[2][3:0]}), 128'({32'd0, 4'b0010}));
      check_eq("tiny_c3_storage", 128'(hist[3][3:0]), 128'(4'b1000));
      check_eq("tiny_c4_dydy", 128'(hist[4][3:0]), 128'(4'b0100));
      check_eq("tiny_c5_done", 128'({done_hist[5], busy_hist[5], busy_hist[6]}), 128'(3'b110));
      $display("phase tiny: size=1 layer_count=1 pass");

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         reset      = ($urandom_range(0, 63) == 0);
         bus0.start = ($urandom_range(0, 3) == 0);
         bus0.stall = ($urandom_range(0, 4) == 0);
         bus1.start = ($urandom_range(0, 3) == 0);
         bus1.stall = ($urandom_range(0, 4) == 0);
         tick();
      end
      reset = 1'b0;
      $display("phase random: 600 cycles");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/backprop_sequencer.md
BACKPROP_SEQUENCER -- requirements
Module: backprop_sequencer

Interface
REQ-001 Parameter size, default 3: neurons (rows) per layer; rows iterate 0..size-1.
REQ-002 Parameter data_size, default 16: datapath word width; carried for parameter-list consistency, unused internally.
REQ-003 Parameter layer_count, default 2: number of weight layers; layers iterate layer_count-1 down to 0.
REQ-004 Parameter backprop_controll_size, default 32*3+4: control bundle width.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request one backprop pass; sampled only in IDLE.
REQ-008 stall  input  1  freeze sequencing while high.
REQ-009 backprop_controll_bundle  output  backprop_controll_size  packed MSB-first {current_layer[31:0], dc_dw_layer[31:0], dc_dw_row[31:0], update_storage, update_dy_dy_old, cal_dc_dw, reset_bit}.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle pulse at pass completion.

Function
REQ-012 The FSM SHALL have states IDLE, CLEAR, CAL, STORE, DYDY, DONE.
REQ-013 IDLE with start=1 SHALL go to CLEAR next cycle, loading layer=layer_count-1, row=0.
REQ-014 CLEAR SHALL assert reset_bit for exactly one cycle, then go to CAL.
REQ-015 CAL SHALL assert cal_dc_dw each non-stalled cycle with dc_dw_row=row, incrementing row; at row=size-1 go to STORE and reset row to 0.
REQ-016 STORE SHALL assert update_storage one cycle, then go to DYDY.
REQ-017 DYDY SHALL assert update_dy_dy_old one cycle; if layer=0 go to DONE, else decrement layer and go to CAL.
REQ-018 DONE SHALL assert done one cycle, then go to IDLE.
REQ-019 current_layer and dc_dw_layer SHALL both equal the layer counter, zero-extended to 32 bits, in every non-IDLE state; both are 0 in IDLE.
REQ-020 dc_dw_row SHALL equal the row counter, zero-extended to 32 bits, in CAL and 0 elsewhere.
REQ-021 Pulse bits SHALL be registered outputs, at most one of the four high in any cycle.
REQ-022 stall=1 in any non-IDLE state SHALL hold state and counters and force all four pulse bits and done to 0; index fields hold their values.
REQ-023 stall in IDLE SHALL have no effect; start and stall both high in IDLE SHALL enter CLEAR, the stall applying from the next cycle.
REQ-024 start while busy SHALL be ignored and not queued.
REQ-025 Unstalled pass latency SHALL be 2 + layer_count*(size+2) cycles from start-sample edge to done pulse inclusive.
REQ-026 size=1 SHALL give a single CAL cycle per layer; layer_count=1 SHALL go from DYDY straight to DONE.

Reset
REQ-027 reset=1 SHALL, at the next edge, force state IDLE, counters 0, bundle all-zero, busy=0, done=0, overriding start and stall.
REQ-028 reset mid-pass SHALL abort without emitting any further pulse; the next pass requires a new start.

Structure
REQ-029 A shared package backprop_pkg SHALL hold the state enum, the 32-bit index width constant and the bundle-width constant.
REQ-030 One sub-module, backprop_index_counter (loadable up/down counter with wrap flag), SHALL implement the row and layer counters.

Verification
REQ-031 size=3, layer_count=2, start pulse at cycle 0 -> reset_bit@1; cal_dc_dw@2-4 rows 0,1,2 layer 1; update_storage@5; update_dy_dy_old@6; cal@7-9 layer 0; storage@10; dydy@11; done@12; busy 1-12.
REQ-032 stall high at cycles 3-4 of the REQ-031 run -> row 1 held with cal_dc_dw=0 for 2 cycles, every later event shifted +2, done@14.
REQ-033 start re-pulsed at cycle 5 of a pass -> no effect, timeline identical to REQ-031.
REQ-034 reset at cycle 8 -> bundle=0, busy=0 at cycle 9; no pulses until new start.
REQ-035 size=1, layer_count=1 -> reset_bit@1, cal@2 row 0, storage@3, dydy@4, done@5.
REQ-036 Every cycle of all runs -> at most one pulse bit high; index fields 0 in IDLE.
